// File: rtl/core85_pkg.sv
// Shared definitions for core85 bus slaves: one-hot FSM encoding, default
// bus widths and decode helpers for the active-low {rd_, wr_} strobe pair.
package core85_pkg;

   localparam int DATASIZE_DEF = 8;
   localparam int ADDRSIZE_DEF = 16;

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      LATCH = 5'b00010,
      WAIT  = 5'b00100,
      XFER  = 5'b01000,
      DONE  = 5'b10000
   } state_e;

   // Strobe pair packed as {rd_, wr_}; both low decodes as a read.
   localparam logic [1:0] STB_NONE  = 2'b11;
   localparam logic [1:0] STB_WRITE = 2'b10;

   function automatic logic strobeActive(input logic [1:0] stb);
      return stb != STB_NONE;
   endfunction

   function automatic logic strobeIsRead(input logic [1:0] stb);
      return (stb != STB_NONE) && (stb != STB_WRITE);
   endfunction

endpackage

// File: rtl/mem85_ram.sv
// Single-port synchronous RAM, one write port and a registered read of the
// same address; contents have no reset so they survive bus resets.
module mem85_ram #(
   parameter int DATASIZE = 8,
   parameter int MEMBITS  = 12
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [MEMBITS-1:0]  addr_i,
   input  logic [DATASIZE-1:0] wdata_i,
   output logic [DATASIZE-1:0] rdata_o
);

   logic [DATASIZE-1:0] mem [0:(1 << MEMBITS) - 1];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      rdata_o <= mem[addr_i];
   end

endmodule

// File: rtl/mem85_bus.sv
// Memory slave on the core85 multiplexed bus with ROM write protection.
// Define MEM85_WAIT_EN to build the wait-state counter that drives READY.
module mem85_bus
   import core85_pkg::*;
#(
   parameter int DATASIZE = DATASIZE_DEF,
   parameter int ADDRSIZE = ADDRSIZE_DEF,
   parameter int MEMBITS  = 12,
   parameter int BASEADDR = 0,
   parameter int ROMBITS  = 10,
   parameter int WAITRD   = 0,
   parameter int WAITWR   = 0
) (
   input  logic                         clk,
   input  logic                         rst_,
   inout  wire  [DATASIZE-1:0]          addrdata,
   input  logic [ADDRSIZE-DATASIZE-1:0] addr,
   input  logic                         ale,
   input  logic                         iom_,
   input  logic                         rd_,
   input  logic                         wr_,
   output logic                         ready,
   output logic                         werr,
   input  logic                         ld_en,
   input  logic [MEMBITS-1:0]           ld_addr,
   input  logic [DATASIZE-1:0]          ld_data
);

   // One extra bit so a window ending at the top of the address space compares cleanly.
   localparam logic [ADDRSIZE:0] WIN_LO = (ADDRSIZE+1)'(BASEADDR);
   localparam logic [ADDRSIZE:0] WIN_HI = WIN_LO + ((ADDRSIZE+1)'(1) << MEMBITS);
   localparam logic [ADDRSIZE:0] ROM_HI = WIN_LO +
      ((ROMBITS == 0) ? (ADDRSIZE+1)'(0) : ((ADDRSIZE+1)'(1) << ROMBITS));

   state_e               state_q, state_d;
   logic [ADDRSIZE-1:0]  addr_q;
   logic                 iomN_q;
   logic                 isRead_q, isRead_d;
   logic                 werr_q, werr_d;
   logic [ADDRSIZE:0]    addrExt;
   logic                 hit, romHit;
   logic [MEMBITS-1:0]   memIdx;
   logic [1:0]           strobe;
   logic                 busDrive, preload, wrCommit;
   logic                 ramWe;
   logic [MEMBITS-1:0]   ramAddr;
   logic [DATASIZE-1:0]  ramWdata, ramRdata;
`ifdef MEM85_WAIT_EN
   logic [3:0]           cnt_q, cnt_d;
   logic                 ready_q, ready_d;
`endif

   assign strobe  = {rd_, wr_};
   assign addrExt = {1'b0, addr_q};
   assign hit     = !iomN_q && (addrExt >= WIN_LO) && (addrExt < WIN_HI);
   assign romHit  = (addrExt >= WIN_LO) && (addrExt < ROM_HI);
   assign memIdx  = addr_q[MEMBITS-1:0] - MEMBITS'(BASEADDR);

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         iomN_q   <= 1'b1;
         isRead_q <= 1'b0;
         werr_q   <= 1'b0;
`ifdef MEM85_WAIT_EN
         cnt_q    <= 4'd0;
         ready_q  <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         isRead_q <= isRead_d;
         werr_q   <= werr_d;
         if (ale) begin
            addr_q <= {addr, addrdata};
            iomN_q <= iom_;
         end
`ifdef MEM85_WAIT_EN
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
`endif
      end
   end

   // ALE overrides every state so aborted and back-to-back cycles restart from LATCH.
   always_comb begin
      state_d  = state_q;
      isRead_d = isRead_q;
`ifdef MEM85_WAIT_EN
      cnt_d    = cnt_q;
`endif
      if (ale) begin
         state_d = LATCH;
`ifdef MEM85_WAIT_EN
         cnt_d   = 4'd0;
`endif
      end else begin
         case (state_q)
            IDLE: ;
            LATCH: begin
               if (strobeActive(strobe)) begin
                  isRead_d = strobeIsRead(strobe);
                  if (!hit) begin
                     state_d = DONE;
                  end else begin
`ifdef MEM85_WAIT_EN
                     cnt_d   = isRead_d ? 4'(WAITRD) : 4'(WAITWR);
                     state_d = (cnt_d != 4'd0) ? WAIT : XFER;
`else
                     state_d = XFER;
`endif
                  end
               end
            end
`ifdef MEM85_WAIT_EN
            WAIT: begin
               if (cnt_q <= 4'd1) begin
                  cnt_d   = 4'd0;
                  state_d = XFER;
               end else begin
                  cnt_d   = cnt_q - 4'd1;
               end
            end
`endif
            XFER: begin
               if (!isRead_q) begin
                  state_d = DONE;
               end else if (rd_) begin
                  state_d = IDLE;
               end
            end
            DONE: begin
               if (rd_ && wr_) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Preload and bus writes share the RAM port; preload only wins while IDLE.
   always_comb begin
      wrCommit = rst_ && !ale && (state_q == XFER) && !isRead_q;
      preload  = rst_ && ld_en && (state_q == IDLE);
      werr_d   = wrCommit && romHit;
      ramWe    = preload || (wrCommit && !romHit);
      ramAddr  = preload ? ld_addr : memIdx;
      ramWdata = preload ? ld_data : addrdata;
      busDrive = (state_q == XFER) && isRead_q && !rd_ && hit;
`ifdef MEM85_WAIT_EN
      ready_d  = (state_d != WAIT);
`endif
   end

   mem85_ram #(
      .DATASIZE (DATASIZE),
      .MEMBITS  (MEMBITS)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ramWe),
      .addr_i  (ramAddr),
      .wdata_i (ramWdata),
      .rdata_o (ramRdata)
   );

   assign addrdata = busDrive ? ramRdata : {DATASIZE{1'bz}};
   assign werr     = werr_q;
`ifdef MEM85_WAIT_EN
   assign ready    = ready_q;
`else
   assign ready    = 1'b1;
`endif

endmodule

// File: doc/mem85_bus.md
# mem85_bus

Synthesisable, parametrised memory slave for the core85 multiplexed address/data bus. It demultiplexes the address on ALE and decodes a memory window. It serves reads and writes with a programmable wait-state count driven onto READY, and write-protects a ROM region at the bottom of the window. It replaces behavioural bench memories and sits directly on the core85 bus pins in both benches and FPGA builds.

## Interface
- DATASIZE, 8, data width and low-address width on `addrdata`
- ADDRSIZE, 16, full address width
- MEMBITS, 12, log2 of window depth in words
- BASEADDR, 0, first address of the window; must be aligned to 2**MEMBITS
- ROMBITS, 10, log2 of the write-protected region at BASEADDR; 0 means no ROM
- WAITRD, 0, wait states per read, 0..15
- WAITWR, 0, wait states per write, 0..15

Ports:
- clk  in  1  system clock; everything is on the rising edge
- rst_  in  1  reset, synchronous, active-low
- addrdata  inout  DATASIZE  muxed low address / data
- addr  in  ADDRSIZE-DATASIZE  high address
- ale  in  1  address latch enable
- iom_  in  1  0 = memory cycle, 1 = I/O cycle (ignored)
- rd_  in  1  read strobe, active-low
- wr_  in  1  write strobe, active-low
- ready  out  1  0 inserts wait states
- werr  out  1  one-cycle pulse on a write into ROM
- ld_en  in  1  preload write enable, only honoured in IDLE
- ld_addr  in  MEMBITS  preload word index
- ld_data  in  DATASIZE  preload data

## Operation
- FSM states: IDLE, LATCH, WAIT, XFER, DONE.
- `ale`=1 at any edge, in any state:
  - latch {addr, addrdata}
  - go to LATCH
  - clear the wait counter
  - this makes back-to-back and aborted cycles restart cleanly.
- LATCH:
  - hit = (iom_==0) and latched address in [BASEADDR, BASEADDR+2**MEMBITS).
  - The array is read at the latched index on the edge after ALE; the read register is valid before `rd_` falls.
- LATCH, strobe (rd_ or wr_) sampled low, hit:
  - load the counter with WAITRD or WAITWR
  - go to WAIT if the loaded value is nonzero, else XFER.
- LATCH, strobe low, miss: go to DONE. Bus is never driven; ready stays 1.
- WAIT: decrement each edge; go to XFER on the edge where the counter reaches 0.
- XFER, read:
  - drive `addrdata` = read register while rd_==0
  - stay in XFER until rd_ returns high, then go to IDLE.
- XFER, write:
  - commit `addrdata` to the array on the first XFER edge, exactly once
  - go to DONE.
  - If the address is in [BASEADDR, BASEADDR+2**ROMBITS), suppress the commit and pulse werr for that cycle.
- DONE: go to IDLE when rd_ and wr_ are both high.
- rd_ and wr_ both low: treated as a read; no write occurs.
- Address arithmetic: index = latched address minus BASEADDR, truncated to MEMBITS. A latched address of 16'hFFFF with the window at the top is a hit; there is no wrap past the window.
- ld_en outside IDLE is ignored.

## Timing
- Reset (rst_=0 at an edge):
  - state IDLE, ready=1, werr=0, addrdata released (z), counter 0
  - array contents preserved
  - reset mid-cycle aborts a pending write; no commit occurs.
- ready is registered:
  - goes 0 on the edge entering WAIT
  - returns to 1 on the edge entering XFER.
  - Wait states seen by the core = WAITRD/WAITWR.
- Read data is driven combinationally from the read register gated by (state==XFER && rd_==0 && hit). Release is combinational on rd_ rising.
- Write commit happens 1 edge after XFER entry. Data must be stable on `addrdata` from wr_ falling.
- ALE to data-valid: 1 clock.

## Configuration
- MEM85_WAIT_EN defined:
  - wait-state counter and WAIT state are built
  - WAITRD/WAITWR are honoured.
- MEM85_WAIT_EN undefined:
  - WAIT state and counter are removed
  - LATCH goes straight to XFER
  - ready is constant 1
  - WAITRD/WAITWR are ignored.

## Structure
- Shared package `core85_pkg`: FSM state encoding (one-hot, 5 bits), DATASIZE/ADDRSIZE defaults, bus-strobe decode constants.
- One sub-module `mem85_ram`: single-port synchronous RAM, MEMBITS×DATASIZE, one write port, registered read. Preload and bus writes are muxed into its single port.
- FSM, decode, counter and tristate stay in the top.

## Test plan
- Preload 0x2000→0x3E, 0x2001→0x55 with BASEADDR=0x2000, WAITRD=0; ALE 0x2000, rd_ low → addrdata=0x3E on the first rd_ cycle; ready stays 1.
- WAITWR=2; write 0xA5 to 0x2400 → ready=0 for exactly 2 cycles; a following read of 0x2400 returns 0xA5.
- ROMBITS=10; write 0x77 to 0x2010 → werr pulses 1 cycle; a following read of 0x2010 returns the original value.
- iom_=1 read at 0x2000, and a memory read at 0x1FFF → addrdata stays z; ready stays 1.
- WAITRD=3; assert rst_=0 during WAIT → next edge gives ready=1, state IDLE, bus z. A subsequent read works normally.
- Build without MEM85_WAIT_EN, WAITRD=5 → ready is never 0; read data is correct on the first rd_ cycle.
